// File: rtl/sfx_arbiter_pkg.sv
// Shared types for the sound-effect arbiter: FSM state codes, effect IDs
// and small helpers that map between effect IDs and pending-bit positions.
package sfx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUSIC = 2'd1,
        ST_SFX   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SFX_NONE  = 2'd0,
        SFX_WHACK = 2'd1,
        SFX_MISS  = 2'd2,
        SFX_GOVER = 2'd3
    } sfx_id_t;

    // Pending register layout: bit 0 WHACK, bit 1 MISS, bit 2 GAMEOVER.
    localparam int PEND_W = 3;

    // Priority encoder over the pending bits: GAMEOVER > MISS > WHACK.
    function automatic sfx_id_t pick_sfx(input logic [PEND_W-1:0] pend);
        sfx_id_t id;
        if (pend[2])      id = SFX_GOVER;
        else if (pend[1]) id = SFX_MISS;
        else if (pend[0]) id = SFX_WHACK;
        else              id = SFX_NONE;
        return id;
    endfunction

    // One-hot pending bit belonging to an effect ID (zero for SFX_NONE).
    function automatic logic [PEND_W-1:0] sfx_bit(input sfx_id_t id);
        logic [PEND_W-1:0] b;
        case (id)
            SFX_WHACK: b = 3'b001;
            SFX_MISS:  b = 3'b010;
            SFX_GOVER: b = 3'b100;
            default:   b = 3'b000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sfx_arbiter_if.sv
// Bundle between the game-state side (sound controller) and the arbiter.
// Signalling: sample_enable, music_rewind and req_* are single-cycle pulses
// sampled on the rising clock edge; music_on is a level. There is no
// back-pressure: requests are latched unconditionally and served by priority.
// On the output side sfx_done is a one-cycle pulse, everything else is a level.
// dbg_state / dbg_pending expose the FSM state and pending register.
interface sfx_arbiter_if
    import sfx_arbiter_pkg::*;
#(
    parameter int AW = 23
) ();

    logic          sample_enable;
    logic          music_on;
    logic          music_rewind;
    logic          req_whack;
    logic          req_miss;
    logic          req_gameover;

    logic [AW-1:0] rom_address;
    logic          audio_valid;
    logic [1:0]    playing_sfx;
    logic [AW-1:0] music_address;
    logic          sfx_done;

    state_t        dbg_state;
    logic [2:0]    dbg_pending;

    // Sound controller side: drives requests, observes playback.
    modport master (
        output sample_enable, music_on, music_rewind,
        output req_whack, req_miss, req_gameover,
        input  rom_address, audio_valid, playing_sfx, music_address, sfx_done,
        input  dbg_state, dbg_pending
    );

    // Arbiter side.
    modport slave (
        input  sample_enable, music_on, music_rewind,
        input  req_whack, req_miss, req_gameover,
        output rom_address, audio_valid, playing_sfx, music_address, sfx_done,
        output dbg_state, dbg_pending
    );

endinterface

// File: rtl/sfx_arbiter_segment_player.sv
// Plays one contiguous ROM segment: loads start/end, advances one address
// per step, and flags when the current address is the last sample.
// A single instance is reloaded for every effect.
module sfx_arbiter_segment_player #(
    parameter int AW = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [AW-1:0] i_start,
    input  logic [AW-1:0] i_end,
    input  logic          i_step,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_end;

    // Load has priority over stepping; stepping stops at the last sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_end  <= '0;
        end else if (i_load) begin
            r_addr <= i_start;
            r_end  <= i_end;
        end else if (i_step && !o_last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == r_end);

endmodule

// File: rtl/sfx_arbiter.sv
// Shares the audio sample ROM read port between background music and the
// WHACK / MISS / GAMEOVER effects. Holds the pending requests, the priority
// grant, the music pointer and the playback FSM; effect addresses come from
// the segment player. The music pointer only moves in MUSIC, so it doubles
// as the saved resume position while an effect plays.
module sfx_arbiter
    import sfx_arbiter_pkg::*;
#(
    parameter int            AW          = 23,
    parameter logic [AW-1:0] MUSIC_START = 23'h0,
    parameter logic [AW-1:0] MUSIC_END   = 23'h4FFFF,
    parameter logic [AW-1:0] WHACK_START = 23'h50000,
    parameter logic [AW-1:0] WHACK_END   = 23'h52FFF,
    parameter logic [AW-1:0] MISS_START  = 23'h53000,
    parameter logic [AW-1:0] MISS_END    = 23'h56FFF,
    parameter logic [AW-1:0] GOVER_START = 23'h57000,
    parameter logic [AW-1:0] GOVER_END   = 23'h5EFFF
) (
    input  logic           clk,
    input  logic           reset,
    sfx_arbiter_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_req;
    logic [PEND_W-1:0]   w_clr;
    sfx_id_t             r_cur;
    sfx_id_t             w_pick;
    sfx_id_t             w_grant_id;
    logic                w_load;
    logic                w_seg_step;
    logic                w_music_step;
    logic [AW-1:0]       r_music_ptr;
    logic [AW-1:0]       r_last_addr;
    logic [AW-1:0]       w_rom_addr;
    logic [AW-1:0]       w_seg_start;
    logic [AW-1:0]       w_seg_end;
    logic [AW-1:0]       w_seg_addr;
    logic                w_seg_last;

    assign w_req  = {bus.req_gameover, bus.req_miss, bus.req_whack};
    assign w_pick = pick_sfx(r_pending);

    // Next-state logic: grants, preemption by GAMEOVER, and stepping enables.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_grant_id   = SFX_NONE;
        w_seg_step   = 1'b0;
        w_music_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = ST_SFX;
                    w_load      = 1'b1;
                    w_grant_id  = w_pick;
                end else if (bus.music_on) begin
                    w_state_nxt = ST_MUSIC;
                end
            end
            ST_MUSIC: begin
                if (|r_pending) begin
                    w_state_nxt = ST_SFX;
                    w_load      = 1'b1;
                    w_grant_id  = w_pick;
                end else if (!bus.music_on) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_music_step = bus.sample_enable;
                end
            end
            ST_SFX: begin
                // Only GAMEOVER may cut into a running lower-priority effect.
                if (r_pending[2] && (r_cur != SFX_GOVER)) begin
                    w_load     = 1'b1;
                    w_grant_id = SFX_GOVER;
                end else if (bus.sample_enable) begin
                    if (w_seg_last) w_state_nxt = ST_DONE;
                    else            w_seg_step  = 1'b1;
                end
            end
            ST_DONE: begin
                if (|r_pending) begin
                    w_state_nxt = ST_SFX;
                    w_load      = 1'b1;
                    w_grant_id  = w_pick;
                end else if (bus.music_on) begin
                    w_state_nxt = ST_MUSIC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Segment bounds for whichever effect is being granted this cycle.
    always_comb begin
        w_seg_start = WHACK_START;
        w_seg_end   = WHACK_END;
        case (w_grant_id)
            SFX_MISS: begin
                w_seg_start = MISS_START;
                w_seg_end   = MISS_END;
            end
            SFX_GOVER: begin
                w_seg_start = GOVER_START;
                w_seg_end   = GOVER_END;
            end
            default: begin
                w_seg_start = WHACK_START;
                w_seg_end   = WHACK_END;
            end
        endcase
    end

    assign w_clr = w_load ? sfx_bit(w_grant_id) : '0;

    // FSM state and currently playing effect ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cur   <= SFX_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_cur <= w_grant_id;
        end
    end

    // Sticky pending bits; a request arriving with its own grant re-arms it.
    always_ff @(posedge clk) begin
        if (reset) r_pending <= '0;
        else       r_pending <= (r_pending & ~w_clr) | w_req;
    end

    // Music pointer: rewind from any state, otherwise step and wrap in MUSIC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_music_ptr <= MUSIC_START;
        end else if (bus.music_rewind) begin
            r_music_ptr <= MUSIC_START;
        end else if (w_music_step) begin
            if (r_music_ptr == MUSIC_END) r_music_ptr <= MUSIC_START;
            else                          r_music_ptr <= r_music_ptr + 1'b1;
        end
    end

    sfx_arbiter_segment_player #(
        .AW (AW)
    ) u_player (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_start (w_seg_start),
        .i_end   (w_seg_end),
        .i_step  (w_seg_step),
        .o_addr  (w_seg_addr),
        .o_last  (w_seg_last)
    );

    // ROM address source: music pointer, effect address, or the held value.
    always_comb begin
        case (r_state)
            ST_MUSIC: w_rom_addr = r_music_ptr;
            ST_SFX:   w_rom_addr = w_seg_addr;
            default:  w_rom_addr = r_last_addr;
        endcase
    end

    // Remember the last presented address so IDLE/DONE can hold it.
    always_ff @(posedge clk) begin
        if (reset) r_last_addr <= MUSIC_START;
        else       r_last_addr <= w_rom_addr;
    end

    assign bus.rom_address   = w_rom_addr;
    assign bus.audio_valid   = (r_state == ST_MUSIC) || (r_state == ST_SFX);
    assign bus.playing_sfx   = (r_state == ST_SFX) ? r_cur : SFX_NONE;
    assign bus.music_address = r_music_ptr;
    assign bus.sfx_done      = (r_state == ST_DONE);
    assign bus.dbg_state     = r_state;
    assign bus.dbg_pending   = r_pending;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter with small ROM segments and a sample
// strobe every 4 clocks. Inputs change 1 time unit after the rising edge;
// outputs are checked at the same point, after the edge has settled.
module tb_sfx_arbiter;
    import sfx_arbiter_pkg::*;

    localparam int AW = 23;

    logic clk;
    logic reset;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];

    sfx_arbiter_if #(.AW(AW)) bus ();

    sfx_arbiter #(
        .AW          (AW),
        .MUSIC_START (23'h100),
        .MUSIC_END   (23'h10F),
        .WHACK_START (23'h200),
        .WHACK_END   (23'h203),
        .MISS_START  (23'h300),
        .MISS_END    (23'h305),
        .GOVER_START (23'h400),
        .GOVER_END   (23'h407)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // count sfx_done pulses
    always @(negedge clk) begin
        if (bus.sfx_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_period();
        bus.sample_enable = 1'b1;
        clk1();
        bus.sample_enable = 1'b0;
        clk1();
        clk1();
        clk1();
    endtask

    task automatic pulse_req(input logic w, input logic m, input logic g);
        bus.req_whack    = w;
        bus.req_miss     = m;
        bus.req_gameover = g;
        clk1();
        bus.req_whack    = 1'b0;
        bus.req_miss     = 1'b0;
        bus.req_gameover = 1'b0;
    endtask

    // Entered with the effect at its start address; leaves one cycle after DONE.
    task automatic play_seg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] id);
        logic [31:0] a;
        for (logic [31:0] x = s; x <= e; x++) exp_q.push_back(x);
        a = exp_q.pop_front();
        chk("seg_start", 32'(bus.rom_address), a);
        chk("seg_id", 32'(bus.playing_sfx), id);
        while (exp_q.size() > 0) begin
            sample_period();
            a = exp_q.pop_front();
            chk("seg_addr", 32'(bus.rom_address), a);
        end
        bus.sample_enable = 1'b1;
        clk1();
        bus.sample_enable = 1'b0;
        chk("seg_done", 32'(bus.sfx_done), 32'h1);
        chk("seg_done_st", 32'(bus.dbg_state), 32'(ST_DONE));
        chk("seg_hold", 32'(bus.rom_address), e);
        chk("seg_done_av", 32'(bus.audio_valid), 32'h0);
        clk1();
    endtask

    initial begin
        int d0;
        reset                = 1'b1;
        bus.sample_enable    = 1'b0;
        bus.music_on         = 1'b0;
        bus.music_rewind     = 1'b0;
        bus.req_whack        = 1'b0;
        bus.req_miss         = 1'b0;
        bus.req_gameover     = 1'b0;
        clk1();
        clk1();

        // 1: reset state, then music with wrap
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("rst_rom", 32'(bus.rom_address), 32'h100);
        chk("rst_music", 32'(bus.music_address), 32'h100);
        chk("rst_av", 32'(bus.audio_valid), 32'h0);
        chk("rst_sfx", 32'(bus.playing_sfx), 32'h0);
        chk("rst_done", 32'(bus.sfx_done), 32'h0);
        chk("rst_pend", 32'(bus.dbg_pending), 32'h0);
        reset        = 1'b0;
        bus.music_on = 1'b1;
        clk1();
        chk("mus_start", 32'(bus.rom_address), 32'h100);
        chk("mus_av", 32'(bus.audio_valid), 32'h1);
        for (int k = 1; k <= 21; k++) begin
            sample_period();
            chk("mus_step", 32'(bus.rom_address), 32'h100 + 32'(k % 16));
        end
        chk("mus_av2", 32'(bus.audio_valid), 32'h1);
        chk("mus_ptr", 32'(bus.music_address), 32'h105);

        // 2: WHACK over music at 0x105
        d0 = done_cnt;
        pulse_req(1'b1, 1'b0, 1'b0);
        chk("wh_pend", 32'(bus.dbg_pending), 32'h1);
        chk("wh_lat_rom", 32'(bus.rom_address), 32'h105);
        clk1();
        chk("wh_state", 32'(bus.dbg_state), 32'(ST_SFX));
        chk("wh_pend_clr", 32'(bus.dbg_pending), 32'h0);
        chk("wh_saved", 32'(bus.music_address), 32'h105);
        play_seg(32'h200, 32'h203, 32'h1);
        chk("wh_resume_st", 32'(bus.dbg_state), 32'(ST_MUSIC));
        chk("wh_resume", 32'(bus.rom_address), 32'h105);
        chk("wh_done_cnt", 32'(done_cnt - d0), 32'h1);
        clk1();
        clk1();

        // 3: WHACK + MISS same cycle -> MISS first, then WHACK
        d0 = done_cnt;
        pulse_req(1'b1, 1'b1, 1'b0);
        chk("both_pend", 32'(bus.dbg_pending), 32'h3);
        clk1();
        chk("both_pend2", 32'(bus.dbg_pending), 32'h1);
        play_seg(32'h300, 32'h305, 32'h2);
        chk("both_next_st", 32'(bus.dbg_state), 32'(ST_SFX));
        play_seg(32'h200, 32'h203, 32'h1);
        chk("both_resume", 32'(bus.rom_address), 32'h105);
        chk("both_done_cnt", 32'(done_cnt - d0), 32'h2);
        clk1();
        clk1();

        // 4: GAMEOVER preempts MISS at 0x302
        pulse_req(1'b0, 1'b1, 1'b0);
        clk1();
        chk("go_miss", 32'(bus.rom_address), 32'h300);
        sample_period();
        sample_period();
        chk("go_at302", 32'(bus.rom_address), 32'h302);
        d0 = done_cnt;
        pulse_req(1'b0, 1'b0, 1'b1);
        chk("go_still_miss", 32'(bus.playing_sfx), 32'h2);
        clk1();
        chk("go_preempt", 32'(bus.rom_address), 32'h400);
        chk("go_no_done", 32'(done_cnt - d0), 32'h0);
        play_seg(32'h400, 32'h407, 32'h3);
        chk("go_resume", 32'(bus.rom_address), 32'h105);
        chk("go_done_cnt", 32'(done_cnt - d0), 32'h1);
        clk1();
        clk1();

        // 5: reset in the middle of WHACK with MISS pending
        pulse_req(1'b1, 1'b0, 1'b0);
        clk1();
        sample_period();
        chk("r5_whack", 32'(bus.rom_address), 32'h201);
        pulse_req(1'b0, 1'b1, 1'b0);
        chk("r5_pend", 32'(bus.dbg_pending), 32'h2);
        chk("r5_no_preempt", 32'(bus.playing_sfx), 32'h1);
        d0    = done_cnt;
        reset = 1'b1;
        clk1();
        chk("r5_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("r5_rom", 32'(bus.rom_address), 32'h100);
        chk("r5_pend0", 32'(bus.dbg_pending), 32'h0);
        chk("r5_sfx", 32'(bus.playing_sfx), 32'h0);
        chk("r5_music", 32'(bus.music_address), 32'h100);
        reset = 1'b0;
        clk1();
        chk("r5_music_st", 32'(bus.dbg_state), 32'(ST_MUSIC));
        for (int k = 1; k <= 8; k++) sample_period();
        chk("r5_no_done", 32'(done_cnt - d0), 32'h0);

        // 6: music_on=0 at 0x108, rewind while idle, restart
        chk("m6_at108", 32'(bus.rom_address), 32'h108);
        bus.music_on = 1'b0;
        clk1();
        chk("m6_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("m6_av", 32'(bus.audio_valid), 32'h0);
        chk("m6_mptr", 32'(bus.music_address), 32'h108);
        sample_period();
        chk("m6_hold", 32'(bus.rom_address), 32'h108);
        bus.music_rewind = 1'b1;
        clk1();
        bus.music_rewind = 1'b0;
        chk("m6_rew_ptr", 32'(bus.music_address), 32'h100);
        chk("m6_rew_hold", 32'(bus.rom_address), 32'h108);
        bus.music_on = 1'b1;
        clk1();
        chk("m6_restart", 32'(bus.rom_address), 32'h100);
        sample_period();
        chk("m6_step", 32'(bus.rom_address), 32'h101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
